// File: rtl/frame_sif_pkg.sv
// rtl/frame_sif_pkg.sv - frame field offsets, dispatcher state encoding and helpers
package frame_sif_pkg;

  localparam int OP_LSB = 0;
  localparam int WD_LSB = 8;

  function automatic int wrs_bit(input int w_width);
    return 8 + w_width;
  endfunction

  function automatic int addr_lsb(input int w_width);
    return 9 + w_width;
  endfunction

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  // Callers zero-extend their vector; supports up to 32 instances.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/frame_sif_fifo.sv
// rtl/frame_sif_fifo.sv - synchronous FIFO with extra-bit pointers and occupancy output
module frame_sif_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == FULL_LVL);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/frame_sif_q.sv
// rtl/frame_sif_q.sv - buffered frame dispatcher issuing one acknowledged transaction at a time
module frame_sif_q
  import frame_sif_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int ADDR_W      = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_vld_in,
  input  logic [FRAME_WIDTH-1:0]    frame_in,
  input  logic [NUM_SW_INST-1:0]    load_in,
  output logic                      frame_rdy,
  input  logic [NUM_SW_INST-1:0]    ack_in,
  output logic [NUM_SW_INST-1:0]    sel_en,
  output logic [7:0]                addr,
  output logic [W_WIDTH-1:0]        wr_data,
  output logic                      wr_rd_s,
  output logic [7:0]                op_id,
  output logic                      busy,
  output logic                      err_load,
  output logic                      err_timeout,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int WRS  = wrs_bit(W_WIDTH);
  localparam int ALSB = addr_lsb(W_WIDTH);
  localparam int EW   = NUM_SW_INST + FRAME_WIDTH;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e                  state_q, state_d;
  logic [NUM_SW_INST-1:0]  load_q, load_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [W_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic                    wr_rd_s_q, wr_rd_s_d;
  logic [7:0]              op_id_q, op_id_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_load_q, err_load_d;

  logic                    accept, load_ok, push, pop;
  logic                    fifo_full, fifo_empty;
  logic [EW-1:0]           fifo_wdata, fifo_rdata;
  logic [NUM_SW_INST-1:0]  head_load;
  logic [FRAME_WIDTH-1:0]  head_frame;
  logic                    hit;

  assign frame_rdy  = ~fifo_full;
  assign accept     = frame_vld_in & frame_rdy;
  assign load_ok    = is_onehot(32'(load_in));
  assign push       = accept & load_ok;
  assign err_load_d = accept & ~load_ok;
  assign fifo_wdata = {load_in, frame_in};
  assign head_load  = fifo_rdata[EW-1 -: NUM_SW_INST];
  assign head_frame = fifo_rdata[FRAME_WIDTH-1:0];
  assign hit        = |(ack_in & load_q);

  frame_sif_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_rd_s_d   = wr_rd_s_q;
    op_id_d     = op_id_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    sel_en      = '0;
    err_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load_d    = head_load;
          op_id_d   = head_frame[OP_LSB +: 8];
          wr_data_d = head_frame[WD_LSB +: W_WIDTH];
          wr_rd_s_d = head_frame[WRS];
          addr_d    = head_frame[ALSB +: ADDR_W];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        sel_en  = load_q;
        cnt_d   = '0;
        state_d = hit ? IDLE : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (hit) begin
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_q     <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_rd_s_q  <= 1'b0;
      op_id_q    <= '0;
      cnt_q      <= '0;
      err_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_rd_s_q  <= wr_rd_s_d;
      op_id_q    <= op_id_d;
      cnt_q      <= cnt_d;
      err_load_q <= err_load_d;
    end
  end

  always_comb begin
    addr = '0;
    addr[ADDR_W-1:0] = addr_q;
  end

  assign wr_data  = wr_data_q;
  assign wr_rd_s  = wr_rd_s_q;
  assign op_id    = op_id_q;
  assign err_load = err_load_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

endmodule
